// File: rtl/svo_axi_regs.sv
// AXI4-lite slave register bank for the video output core: eight 32-bit registers,
// static configuration outputs, status readback and a soft-reset pulse.
module svo_axi_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5356_4F31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [31:0]       axi_awaddr,
    input  logic [2:0]        axi_awprot,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [31:0]       axi_wdata,
    input  logic [3:0]        axi_wstrb,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [1:0]        axi_bresp,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [31:0]       axi_araddr,
    input  logic [2:0]        axi_arprot,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [31:0]       axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic [31:0]       cfg_ctrl,
    output logic [5*32-1:0]   cfg_word,
    input  logic [31:0]       status,
    output logic              soft_reset
);

    localparam int unsigned DW     = 32;
    localparam int unsigned NWORD  = 5;
    localparam int unsigned WIN_SZ = 32;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [DW-1:0]             rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      soft_reset_q, soft_reset_d;
    logic [DW-1:0]             ctrl_q, ctrl_d;
    logic [NWORD-1:0][DW-1:0]  word_q, word_d;
    logic [DW-1:0]             waddr_q, waddr_d;
    logic [DW-1:0]             wdata_q, wdata_d;
    logic [3:0]                wstrb_q, wstrb_d;

    logic [DW-1:0]             wr_off_c, rd_off_c;
    logic                      wr_win_c, rd_win_c;
    logic [2:0]                wr_idx_c, rd_idx_c;
    logic                      commit_c;
    logic                      unused_c;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [3:0]    strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Window decode; subtraction wraps so addresses below BASE_ADDR fall outside.
    assign wr_off_c = waddr_q - BASE_ADDR;
    assign rd_off_c = axi_araddr - BASE_ADDR;
    assign wr_win_c = wr_off_c < DW'(WIN_SZ);
    assign rd_win_c = rd_off_c < DW'(WIN_SZ);
    assign wr_idx_c = wr_off_c[4:2];
    assign rd_idx_c = rd_off_c[4:2];
    assign commit_c = !awready_q && !wready_q && !bvalid_q;
    assign unused_c = ^{axi_awprot, axi_arprot, wr_off_c[1:0], rd_off_c[1:0]};

    always_comb begin
        awready_d    = awready_q;
        wready_d     = wready_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        arready_d    = arready_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        soft_reset_d = 1'b0;
        ctrl_d       = ctrl_q;
        word_d       = word_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;

        if (axi_awvalid && awready_q) begin
            awready_d = 1'b0;
            waddr_d   = axi_awaddr;
        end
        if (axi_wvalid && wready_q) begin
            wready_d = 1'b0;
            wdata_d  = axi_wdata;
            wstrb_d  = axi_wstrb;
        end

        // Commit one cycle after both address and data are held.
        if (commit_c) begin
            bvalid_d = 1'b1;
            if (!wr_win_c) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
                case (wr_idx_c)
                    3'd0: begin
                        ctrl_d       = merge_bytes(ctrl_q, wdata_q, wstrb_q) & ~DW'(2);
                        soft_reset_d = wstrb_q[0] && wdata_q[1];
                    end
                    3'd2, 3'd3, 3'd4, 3'd5, 3'd6:
                        word_d[wr_idx_c - 3'd2] = merge_bytes(word_q[wr_idx_c - 3'd2], wdata_q, wstrb_q);
                    default: ;
                endcase
            end
        end
        if (bvalid_q && axi_bready) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end

        // Read data is sampled from register state as of the AR handshake.
        if (axi_arvalid && arready_q) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            if (!rd_win_c) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rresp_d = RESP_OKAY;
                case (rd_idx_c)
                    3'd0:    rdata_d = ctrl_q;
                    3'd1:    rdata_d = status;
                    3'd7:    rdata_d = ID_VALUE;
                    default: rdata_d = word_q[rd_idx_c - 3'd2];
                endcase
            end
        end
        if (rvalid_q && axi_rready) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            awready_q    <= 1'b1;
            wready_q     <= 1'b1;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            arready_q    <= 1'b1;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            soft_reset_q <= 1'b0;
            ctrl_q       <= '0;
            word_q       <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            soft_reset_q <= soft_reset_d;
            ctrl_q       <= ctrl_d;
            word_q       <= word_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign cfg_ctrl    = ctrl_q;
    assign cfg_word    = word_q;
    assign soft_reset  = soft_reset_q;

endmodule

// File: tb/tb_svo_axi_regs.sv
// Bench for svo_axi_regs: hand-written vector table, corner sequences and
// randomized traffic checked against a simple register-map model.
module tb_svo_axi_regs;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] ID   = 32'h5356_4F31;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SERR = 2'b10;

    logic         clk = 1'b0;
    logic         reset;
    logic         axi_awvalid, axi_awready;
    logic [31:0]  axi_awaddr;
    logic [2:0]   axi_awprot;
    logic         axi_wvalid, axi_wready;
    logic [31:0]  axi_wdata;
    logic [3:0]   axi_wstrb;
    logic         axi_bvalid, axi_bready;
    logic [1:0]   axi_bresp;
    logic         axi_arvalid, axi_arready;
    logic [31:0]  axi_araddr;
    logic [2:0]   axi_arprot;
    logic         axi_rvalid, axi_rready;
    logic [31:0]  axi_rdata;
    logic [1:0]   axi_rresp;
    logic [31:0]  cfg_ctrl;
    logic [159:0] cfg_word;
    logic [31:0]  status;
    logic         soft_reset;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mdl [0:7];

    svo_axi_regs #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
        .clk(clk), .reset(reset),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .cfg_ctrl(cfg_ctrl), .cfg_word(cfg_word), .status(status), .soft_reset(soft_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference register map: byte offset decides everything.
    function automatic bit in_win(input logic [31:0] addr);
        return (addr - BASE) < 32'd32;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off / 4);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        if (!in_win(addr)) return 32'h0;
        if (widx(addr) == 1) return status;
        if (widx(addr) == 7) return ID;
        return mdl[widx(addr)];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return in_win(addr) ? OKAY : SERR;
    endfunction

    function automatic bit exp_sr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        return in_win(addr) && widx(addr) == 0 && strb[0] && data[1];
    endfunction

    function automatic logic [159:0] exp_words();
        return {mdl[6], mdl[5], mdl[4], mdl[3], mdl[2]};
    endfunction

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int i;
        if (!in_win(addr)) return;
        i = widx(addr);
        if (i == 1 || i == 7) return;
        for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[i][8*b +: 8] = data[8*b +: 8];
        if (i == 0) mdl[0][1] = 1'b0;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bdly, input logic [1:0] eresp, input bit esr);
        bit aw_done = 0, w_done = 0;
        int a_start = (lead > 0) ? lead : 0;
        int w_start = (lead < 0) ? -lead : 0;
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
        for (int t = 0; t < 50 && !(aw_done && w_done); t++) begin
            axi_awvalid = !aw_done && t >= a_start;
            axi_wvalid  = !w_done && t >= w_start;
            check("bvalid_before_capture", axi_bvalid, 1'b0);
            if (axi_awvalid && axi_awready) aw_done = 1;
            if (axi_wvalid && axi_wready) w_done = 1;
            @(negedge clk);
        end
        axi_awvalid = 0; axi_wvalid = 0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 1'b0, 1'b1);
        check("bvalid_latency", axi_bvalid, 1'b0);
        check("aw_held_ready", axi_awready, 1'b0);
        mdl_write(addr, data, strb);
        @(negedge clk);
        check("bvalid", axi_bvalid, 1'b1);
        check("bresp", axi_bresp, eresp);
        check("soft_reset_pulse", soft_reset, esr);
        check("cfg_ctrl", cfg_ctrl, mdl[0]);
        check("cfg_word", cfg_word, exp_words());
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            check("bvalid_hold", axi_bvalid, 1'b1);
            check("bresp_hold", axi_bresp, eresp);
            check("awready_hold", axi_awready, 1'b0);
            check("wready_hold", axi_wready, 1'b0);
            check("soft_reset_once", soft_reset, 1'b0);
        end
        axi_bready = 1;
        @(negedge clk);
        axi_bready = 0;
        check("bvalid_clear", axi_bvalid, 1'b0);
        check("awready_back", axi_awready, 1'b1);
        check("wready_back", axi_wready, 1'b1);
        check("soft_reset_low", soft_reset, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdly,
                           input logic [31:0] edata, input logic [1:0] eresp);
        bit hs = 0;
        axi_araddr = addr; axi_arvalid = 1;
        for (int t = 0; t < 50 && !hs; t++) begin
            hs = axi_arready;
            @(negedge clk);
        end
        axi_arvalid = 0;
        if (!hs) check("read_handshake_timeout", 1'b0, 1'b1);
        check("rvalid", axi_rvalid, 1'b1);
        check("rdata", axi_rdata, edata);
        check("rresp", axi_rresp, eresp);
        check("arready_busy", axi_arready, 1'b0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("rvalid_hold", axi_rvalid, 1'b1);
            check("rdata_hold", axi_rdata, edata);
            check("rresp_hold", axi_rresp, eresp);
        end
        axi_rready = 1;
        @(negedge clk);
        axi_rready = 0;
        check("rvalid_clear", axi_rvalid, 1'b0);
        check("arready_back", axi_arready, 1'b1);
    endtask

    task automatic check_idle_reset();
        check("rst_awready", axi_awready, 1'b1);
        check("rst_wready", axi_wready, 1'b1);
        check("rst_arready", axi_arready, 1'b1);
        check("rst_bvalid", axi_bvalid, 1'b0);
        check("rst_rvalid", axi_rvalid, 1'b0);
        check("rst_bresp", axi_bresp, 2'b00);
        check("rst_rresp", axi_rresp, 2'b00);
        check("rst_rdata", axi_rdata, 32'h0);
        check("rst_cfg_ctrl", cfg_ctrl, 32'h0);
        check("rst_cfg_word", cfg_word, 160'h0);
        check("rst_soft_reset", soft_reset, 1'b0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          sr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                                int lead, int dly, logic [1:0] resp, logic [31:0] rdata, bit sr);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.lead = lead;
        v.dly = dly; v.resp = resp; v.rdata = rdata; v.sr = sr;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 32'h08, 32'h1234_5678, 4'hF, 0, 0, OKAY, 32'h0, 0);
        vecs[1]  = mk(0, 32'h08, 32'h0, 4'h0, 0, 0, OKAY, 32'h1234_5678, 0);
        vecs[2]  = mk(1, 32'h0C, 32'hAABB_CCDD, 4'h5, 3, 0, OKAY, 32'h0, 0);
        vecs[3]  = mk(0, 32'h0C, 32'h0, 4'h0, 0, 0, OKAY, 32'h00BB_00DD, 0);
        vecs[4]  = mk(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, SERR, 32'h0, 0);
        vecs[5]  = mk(0, 32'h24, 32'h0, 4'h0, 0, 0, SERR, 32'h0, 0);
        vecs[6]  = mk(0, 32'h1C, 32'h0, 4'h0, 0, 0, OKAY, 32'h5356_4F31, 0);
        vecs[7]  = mk(1, 32'h04, 32'hDEAD_BEEF, 4'hF, -2, 0, OKAY, 32'h0, 0);
        vecs[8]  = mk(0, 32'h04, 32'h0, 4'h0, 0, 0, OKAY, 32'hCAFE_0001, 0);
        vecs[9]  = mk(1, 32'h00, 32'h0000_0003, 4'hF, 0, 0, OKAY, 32'h0, 1);
        vecs[10] = mk(0, 32'h00, 32'h0, 4'h0, 0, 0, OKAY, 32'h0000_0001, 0);
        vecs[11] = mk(1, 32'h18, 32'hA5A5_A5A5, 4'hF, 1, 5, OKAY, 32'h0, 0);
        vecs[12] = mk(0, 32'h18, 32'h0, 4'h0, 0, 4, OKAY, 32'hA5A5_A5A5, 0);
        vecs[13] = mk(1, 32'h1F, 32'h0, 4'hF, 0, 0, OKAY, 32'h0, 0);
        vecs[14] = mk(0, 32'h1E, 32'h0, 4'h0, 0, 0, OKAY, 32'h5356_4F31, 0);
        vecs[15] = mk(0, 32'h08, 32'h0, 4'h0, 0, 0, OKAY, 32'h1234_5678, 0);
        vecs[16] = mk(1, 32'hFFFF_FFFC, 32'h0000_FFFF, 4'hF, 0, 0, SERR, 32'h0, 0);
        vecs[17] = mk(0, 32'h00, 32'h0, 4'h0, 0, 0, OKAY, 32'h0000_0001, 0);

        reset = 1;
        axi_awvalid = 0; axi_awaddr = 0; axi_awprot = 0;
        axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_bready = 0;
        axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0; axi_rready = 0;
        status = 32'hCAFE_0001;
        mdl_clear();
        repeat (3) @(negedge clk);
        reset = 0;
        check_idle_reset();

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, vecs[i].dly,
                         vecs[i].resp, vecs[i].sr);
            else
                do_read(vecs[i].addr, vecs[i].dly, vecs[i].rdata, vecs[i].resp);
        end
        check("status_passthrough", exp_rdata(32'h04), 32'hCAFE_0001);

        // Read handshake on the commit edge of a write to the same register.
        do_write(32'h10, 32'h1111_2222, 4'hF, 0, 0, OKAY, 0);
        axi_awaddr = 32'h10; axi_wdata = 32'h3333_4444; axi_wstrb = 4'hF;
        axi_awvalid = 1; axi_wvalid = 1;
        @(negedge clk);
        axi_awvalid = 0; axi_wvalid = 0;
        axi_araddr = 32'h10; axi_arvalid = 1;
        @(negedge clk);
        axi_arvalid = 0;
        mdl_write(32'h10, 32'h3333_4444, 4'hF);
        check("same_cycle_bvalid", axi_bvalid, 1'b1);
        check("same_cycle_rvalid", axi_rvalid, 1'b1);
        check("same_cycle_rdata_old", axi_rdata, 32'h1111_2222);
        check("same_cycle_cfg_word", cfg_word, exp_words());
        axi_bready = 1; axi_rready = 1;
        @(negedge clk);
        axi_bready = 0; axi_rready = 0;
        check("same_cycle_bclear", axi_bvalid, 1'b0);
        check("same_cycle_rclear", axi_rvalid, 1'b0);
        do_read(32'h10, 0, 32'h3333_4444, OKAY);

        // Reset while a write response is pending.
        axi_awaddr = 32'h14; axi_wdata = 32'h0000_0055; axi_wstrb = 4'hF;
        axi_awvalid = 1; axi_wvalid = 1;
        @(negedge clk);
        axi_awvalid = 0; axi_wvalid = 0;
        @(negedge clk);
        check("midrst_bvalid_pending", axi_bvalid, 1'b1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        mdl_clear();
        check_idle_reset();
        do_read(32'h08, 0, 32'h0, OKAY);

        // Randomized traffic against the register-map model.
        for (int it = 0; it < 120; it++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            int          ld, dl;
            if ($urandom_range(0, 7) == 0) status = $urandom();
            if ($urandom_range(0, 4) == 0) a = $urandom();
            else a = BASE + 32'($urandom_range(0, 10) * 4 + $urandom_range(0, 3));
            d  = $urandom();
            s  = 4'($urandom_range(0, 15));
            ld = int'($urandom_range(0, 6)) - 3;
            dl = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, s, ld, dl, exp_resp(a), exp_sr(a, d, s));
            else
                do_read(a, dl, exp_rdata(a), exp_resp(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
